// File: rtl/control_unit_multicycle.sv
// Multicycle control unit: walks each instruction through IFH/ID/EX/MEM/WB
// with a per-opcode stage path, raises each datapath strobe only in the
// stage that uses it, stalls MEM on mem_ready and supports halt/resume.
// Handshakes: instr_valid is consumed only in IFH and mem_ready only in MEM;
// a stage advances on the cycle its input is high, and that input is
// ignored in every other stage.
module control_unit_multicycle #(
  parameter int OPCODE_W    = 6,
  parameter int FUNCT_W     = 6,
  parameter int BRANCH_W    = 3,
  parameter int HALT_RESUME = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                instr_valid,
  input  logic                mem_ready,
  input  logic                resume,
  output logic [2:0]          stage,
  output logic                ir_load,
  output logic                read_reg,
  output logic                write_reg,
  output logic                read_data,
  output logic                write_data,
  output logic                immediat,
  output logic                control_function,
  output logic                control_alu_data,
  output logic                push,
  output logic                pop,
  output logic                add_pc,
  output logic                reg_control,
  output logic                brfl_control,
  output logic [FUNCT_W-1:0]  fnction,
  output logic [BRANCH_W-1:0] branch,
  output logic                write_pc,
  output logic                halted,
  output logic                illegal
);

  localparam logic [2:0] S_IFH    = 3'b000;
  localparam logic [2:0] S_ID     = 3'b001;
  localparam logic [2:0] S_EX     = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB     = 3'b100;
  localparam logic [2:0] S_HALTED = 3'b111;

  // Instruction classes kept after decode; they select path and strobes.
  localparam logic [3:0] C_R    = 4'd0;
  localparam logic [3:0] C_I    = 4'd1;
  localparam logic [3:0] C_LW   = 4'd2;
  localparam logic [3:0] C_SW   = 4'd3;
  localparam logic [3:0] C_CALL = 4'd4;
  localparam logic [3:0] C_RET  = 4'd5;
  localparam logic [3:0] C_JR   = 4'd6;
  localparam logic [3:0] C_JPC  = 4'd7;
  localparam logic [3:0] C_BRFL = 4'd8;
  localparam logic [3:0] C_NOP  = 4'd9;
  localparam logic [3:0] C_HALT = 4'd10;
  localparam logic [3:0] C_ILL  = 4'd11;

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(6'b001110);
  localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(6'b001100);
  localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(6'b001101);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_CALL = OPCODE_W'(6'b000011);
  localparam logic [OPCODE_W-1:0] OP_RET  = OPCODE_W'(6'b000111);
  localparam logic [OPCODE_W-1:0] OP_JR   = OPCODE_W'(6'b011000);
  localparam logic [OPCODE_W-1:0] OP_JPC  = OPCODE_W'(6'b001001);
  localparam logic [OPCODE_W-1:0] OP_BRFL = OPCODE_W'(6'b010001);
  localparam logic [OPCODE_W-1:0] OP_NOP  = OPCODE_W'(6'b000001);
  localparam logic [OPCODE_W-1:0] OP_HALT = OPCODE_W'(6'b000010);

  logic [2:0]          state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q, opcode_d;
  logic [3:0]          cls_q, cls_d, id_cls;
  logic [FUNCT_W-1:0]  fn_q, fn_d, id_fn;
  logic [BRANCH_W-1:0] br_q, br_d, id_br;

  // Decode the latched opcode (never the live input) into class and fields.
  always_comb begin
    id_cls = C_ILL;
    id_fn  = '0;
    id_br  = '0;
    case (opcode_q)
      OP_R:    id_cls = C_R;
      OP_ADDI: begin id_cls = C_I;    id_fn = FUNCT_W'(6'b100000); end
      OP_SUBI: begin id_cls = C_I;    id_fn = FUNCT_W'(6'b100010); end
      OP_ANDI: begin id_cls = C_I;    id_fn = FUNCT_W'(6'b100100); end
      OP_ORI:  begin id_cls = C_I;    id_fn = FUNCT_W'(6'b100101); end
      OP_LW:   begin id_cls = C_LW;   id_fn = FUNCT_W'(6'b100000); end
      OP_SW:   begin id_cls = C_SW;   id_fn = FUNCT_W'(6'b100000); end
      OP_CALL: begin id_cls = C_CALL; id_br = BRANCH_W'(3'b010); end
      OP_RET:  id_cls = C_RET;
      OP_JR:   begin id_cls = C_JR;   id_br = BRANCH_W'(3'b001); end
      OP_JPC:  begin id_cls = C_JPC;  id_br = BRANCH_W'(3'b100); end
      OP_BRFL: begin id_cls = C_BRFL; id_fn = '1; end
      OP_NOP:  id_cls = C_NOP;
      OP_HALT: begin id_cls = C_HALT; id_br = BRANCH_W'(3'b011); end
      default: id_cls = C_ILL;
    endcase
  end

  // Next-state sequencing and per-stage strobe generation.
  always_comb begin
    state_d          = state_q;
    opcode_d         = opcode_q;
    cls_d            = cls_q;
    fn_d             = fn_q;
    br_d             = br_q;
    ir_load          = 1'b0;
    read_reg         = 1'b0;
    write_reg        = 1'b0;
    read_data        = 1'b0;
    write_data       = 1'b0;
    immediat         = 1'b0;
    control_function = 1'b0;
    control_alu_data = 1'b0;
    push             = 1'b0;
    pop              = 1'b0;
    add_pc           = 1'b0;
    reg_control      = 1'b0;
    brfl_control     = 1'b0;
    fnction          = '0;
    branch           = '0;
    write_pc         = 1'b0;
    halted           = 1'b0;
    illegal          = 1'b0;
    case (state_q)
      S_IFH: begin
        // Gated by rst so nothing is visible while reset is held.
        if (instr_valid && !rst) begin
          ir_load  = 1'b1;
          opcode_d = opcode;
          state_d  = S_ID;
        end
      end
      S_ID: begin
        cls_d    = id_cls;
        fn_d     = id_fn;
        br_d     = id_br;
        read_reg = id_cls inside {C_R, C_I, C_LW, C_SW, C_JR, C_BRFL};
        illegal  = (id_cls == C_ILL);
        case (id_cls)
          C_NOP, C_ILL: begin write_pc = 1'b1; state_d = S_IFH; end
          C_HALT:       state_d = S_HALTED;
          default:      state_d = S_EX;
        endcase
      end
      S_EX: begin
        fnction          = fn_q;
        branch           = br_q;
        control_function = cls_q inside {C_R, C_I, C_LW, C_SW, C_BRFL};
        immediat         = cls_q inside {C_I, C_LW, C_SW};
        control_alu_data = cls_q inside {C_LW, C_SW};
        push             = (cls_q == C_CALL);
        pop              = (cls_q == C_RET);
        add_pc           = (cls_q == C_RET);
        brfl_control     = (cls_q == C_BRFL);
        case (cls_q)
          C_R, C_I:   state_d = S_WB;
          C_LW, C_SW: state_d = S_MEM;
          default:    begin write_pc = 1'b1; state_d = S_IFH; end
        endcase
      end
      S_MEM: begin
        control_alu_data = 1'b1;
        read_data        = (cls_q == C_LW);
        write_data       = (cls_q == C_SW);
        if (mem_ready) begin
          if (cls_q == C_SW) begin
            write_pc = 1'b1;
            state_d  = S_IFH;
          end else begin
            state_d  = S_WB;
          end
        end
      end
      S_WB: begin
        write_reg   = 1'b1;
        reg_control = cls_q inside {C_I, C_LW};
        read_data   = (cls_q == C_LW);
        write_pc    = 1'b1;
        state_d     = S_IFH;
      end
      S_HALTED: begin
        halted = 1'b1;
        if ((HALT_RESUME != 0) && resume) begin
          write_pc = 1'b1;
          state_d  = S_IFH;
        end
      end
      default: state_d = S_IFH;
    endcase
  end

  assign stage = state_q;

  // State and decoded-field registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IFH;
      opcode_q <= '0;
      cls_q    <= C_NOP;
      fn_q     <= '0;
      br_q     <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cls_q    <= cls_d;
      fn_q     <= fn_d;
      br_q     <= br_d;
    end
  end

endmodule

// File: tb/tb_control_unit_multicycle.sv
// Bench for control_unit_multicycle: a cycle-by-cycle vector table with
// hand-computed stage/strobe expectations, run against a HALT_RESUME=1 and
// a HALT_RESUME=0 instance in parallel, plus a long MEM-stall sequence.
module tb_control_unit_multicycle;

  // Strobe bit masks, packed in the same order as act_str below.
  localparam logic [15:0] IRL = 16'h8000, RR  = 16'h4000, WR  = 16'h2000;
  localparam logic [15:0] RD  = 16'h1000, WD  = 16'h0800, IMM = 16'h0400;
  localparam logic [15:0] CF  = 16'h0200, CAD = 16'h0100, PSH = 16'h0080;
  localparam logic [15:0] POP = 16'h0040, APC = 16'h0020, RC  = 16'h0010;
  localparam logic [15:0] BFC = 16'h0008, WPC = 16'h0004, HLT = 16'h0002;
  localparam logic [15:0] ILL = 16'h0001, NONE = 16'h0000;

  localparam logic [2:0] IFH = 3'b000, ID = 3'b001, EX = 3'b010;
  localparam logic [2:0] MEM = 3'b011, WB = 3'b100, HTD = 3'b111;

  localparam logic [5:0] OP_R = 6'b000000, OP_SUBI = 6'b001110, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_CALL = 6'b000011;
  localparam logic [5:0] OP_RET = 6'b000111, OP_JR = 6'b011000, OP_JPC = 6'b001001;
  localparam logic [5:0] OP_BRFL = 6'b010001, OP_NOP = 6'b000001, OP_HALT = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111, JUNK = 6'b101011;

  typedef struct {
    logic       r, v, m, s;
    logic [5:0] opc;
    logic [2:0] stg;
    logic [15:0] str;
    logic [5:0] fn;
    logic [2:0] br;
    logic [2:0] stg_nr;
    logic [15:0] str_nr;
  } vec_t;

  // Clock/reset and stimulus signals.
  logic clk = 1'b0;
  logic rst, instr_valid, mem_ready, resume;
  logic [5:0] opcode;
  always #5 clk = ~clk;

  // HALT_RESUME=1 instance outputs.
  logic [2:0] stage;
  logic ir_load, read_reg, write_reg, read_data, write_data, immediat;
  logic control_function, control_alu_data, push, pop, add_pc, reg_control;
  logic brfl_control, write_pc, halted, illegal;
  logic [5:0] fnction;
  logic [2:0] branch;

  // HALT_RESUME=0 instance outputs.
  logic [2:0] n_stage;
  logic n_ir_load, n_read_reg, n_write_reg, n_read_data, n_write_data, n_immediat;
  logic n_control_function, n_control_alu_data, n_push, n_pop, n_add_pc, n_reg_control;
  logic n_brfl_control, n_write_pc, n_halted, n_illegal;
  logic [5:0] n_fnction;
  logic [2:0] n_branch;

  control_unit_multicycle #(.OPCODE_W(6), .FUNCT_W(6), .BRANCH_W(3), .HALT_RESUME(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .resume(resume), .stage(stage), .ir_load(ir_load),
    .read_reg(read_reg), .write_reg(write_reg), .read_data(read_data),
    .write_data(write_data), .immediat(immediat), .control_function(control_function),
    .control_alu_data(control_alu_data), .push(push), .pop(pop), .add_pc(add_pc),
    .reg_control(reg_control), .brfl_control(brfl_control), .fnction(fnction),
    .branch(branch), .write_pc(write_pc), .halted(halted), .illegal(illegal)
  );

  control_unit_multicycle #(.OPCODE_W(6), .FUNCT_W(6), .BRANCH_W(3), .HALT_RESUME(0)) dut_nr (
    .clk(clk), .rst(rst), .opcode(opcode), .instr_valid(instr_valid),
    .mem_ready(mem_ready), .resume(resume), .stage(n_stage), .ir_load(n_ir_load),
    .read_reg(n_read_reg), .write_reg(n_write_reg), .read_data(n_read_data),
    .write_data(n_write_data), .immediat(n_immediat), .control_function(n_control_function),
    .control_alu_data(n_control_alu_data), .push(n_push), .pop(n_pop), .add_pc(n_add_pc),
    .reg_control(n_reg_control), .brfl_control(n_brfl_control), .fnction(n_fnction),
    .branch(n_branch), .write_pc(n_write_pc), .halted(n_halted), .illegal(n_illegal)
  );

  logic [15:0] act_str, act_str_nr;
  assign act_str = {ir_load, read_reg, write_reg, read_data, write_data, immediat,
                    control_function, control_alu_data, push, pop, add_pc, reg_control,
                    brfl_control, write_pc, halted, illegal};
  assign act_str_nr = {n_ir_load, n_read_reg, n_write_reg, n_read_data, n_write_data,
                       n_immediat, n_control_function, n_control_alu_data, n_push, n_pop,
                       n_add_pc, n_reg_control, n_brfl_control, n_write_pc, n_halted,
                       n_illegal};

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic v, input logic m, input logic s,
                     input logic [5:0] opc, input logic [2:0] stg, input logic [15:0] str,
                     input logic [5:0] fn, input logic [2:0] br);
    vec_t t;
    t.r = r; t.v = v; t.m = m; t.s = s; t.opc = opc;
    t.stg = stg; t.str = str; t.fn = fn; t.br = br;
    t.stg_nr = stg; t.str_nr = str;
    vecs.push_back(t);
  endtask

  // Override the HALT_RESUME=0 expectation of the most recent vector.
  task automatic set_nr(input logic [2:0] stg, input logic [15:0] str);
    vec_t t;
    t = vecs.pop_back();
    t.stg_nr = stg; t.str_nr = str;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic r, input logic v, input logic m, input logic s,
                       input logic [5:0] opc);
    rst = r; instr_valid = v; mem_ready = m; resume = s; opcode = opc;
  endtask

  int rd_cnt, wr_cnt, wpc_cnt;

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, OP_R);

    // Reset, idle, and resume ignored outside HALTED.
    add(1, 1, 1, 0, OP_R,   IFH, NONE, 0, 0);
    add(1, 0, 1, 0, OP_R,   IFH, NONE, 0, 0);
    add(0, 0, 1, 1, OP_R,   IFH, NONE, 0, 0);
    // R-type; opcode/instr_valid changes after IFH must not matter.
    add(0, 1, 1, 0, OP_R,   IFH, IRL, 0, 0);
    add(0, 0, 1, 0, OP_BAD, ID,  RR, 0, 0);
    add(0, 1, 1, 0, JUNK,   EX,  CF, 0, 0);
    add(0, 0, 1, 0, JUNK,   WB,  WR | WPC, 0, 0);
    // lw with three stalled MEM cycles.
    add(0, 1, 0, 0, OP_LW,  IFH, IRL, 0, 0);
    add(0, 0, 0, 0, JUNK,   ID,  RR, 0, 0);
    add(0, 0, 0, 0, JUNK,   EX,  IMM | CF | CAD, 6'b100000, 0);
    add(0, 0, 0, 0, JUNK,   MEM, CAD | RD, 0, 0);
    add(0, 0, 0, 0, JUNK,   MEM, CAD | RD, 0, 0);
    add(0, 0, 0, 0, JUNK,   MEM, CAD | RD, 0, 0);
    add(0, 0, 1, 0, JUNK,   MEM, CAD | RD, 0, 0);
    add(0, 0, 0, 0, JUNK,   WB,  WR | RC | RD | WPC, 0, 0);
    // sw with immediate mem_ready.
    add(0, 1, 1, 0, OP_SW,  IFH, IRL, 0, 0);
    add(0, 0, 1, 0, JUNK,   ID,  RR, 0, 0);
    add(0, 0, 1, 0, JUNK,   EX,  IMM | CF | CAD, 6'b100000, 0);
    add(0, 0, 1, 0, JUNK,   MEM, CAD | WD | WPC, 0, 0);
    // subi and ori.
    add(0, 1, 1, 0, OP_SUBI, IFH, IRL, 0, 0);
    add(0, 0, 1, 0, JUNK,   ID,  RR, 0, 0);
    add(0, 0, 1, 0, JUNK,   EX,  IMM | CF, 6'b100010, 0);
    add(0, 0, 1, 0, JUNK,   WB,  WR | RC | WPC, 0, 0);
    add(0, 1, 1, 0, OP_ORI, IFH, IRL, 0, 0);
    add(0, 0, 1, 0, JUNK,   ID,  RR, 0, 0);
    add(0, 0, 1, 0, JUNK,   EX,  IMM | CF, 6'b100101, 0);
    add(0, 0, 1, 0, JUNK,   WB,  WR | RC | WPC, 0, 0);
    // Branch class.
    add(0, 1, 1, 0, OP_CALL, IFH, IRL, 0, 0);
    add(0, 0, 1, 0, JUNK,   ID,  NONE, 0, 0);
    add(0, 0, 1, 0, JUNK,   EX,  PSH | WPC, 0, 3'b010);
    add(0, 1, 1, 0, OP_RET, IFH, IRL, 0, 0);
    add(0, 0, 1, 0, JUNK,   ID,  NONE, 0, 0);
    add(0, 0, 1, 0, JUNK,   EX,  POP | APC | WPC, 0, 0);
    add(0, 1, 1, 0, OP_JR,  IFH, IRL, 0, 0);
    add(0, 0, 1, 0, JUNK,   ID,  RR, 0, 0);
    add(0, 0, 1, 0, JUNK,   EX,  WPC, 0, 3'b001);
    add(0, 1, 1, 0, OP_JPC, IFH, IRL, 0, 0);
    add(0, 0, 1, 0, JUNK,   ID,  NONE, 0, 0);
    add(0, 0, 1, 0, JUNK,   EX,  WPC, 0, 3'b100);
    add(0, 1, 1, 0, OP_BRFL, IFH, IRL, 0, 0);
    add(0, 0, 1, 0, JUNK,   ID,  RR, 0, 0);
    add(0, 0, 1, 0, JUNK,   EX,  CF | BFC | WPC, 6'b111111, 0);
    // nop and illegal retire in ID.
    add(0, 1, 1, 0, OP_NOP, IFH, IRL, 0, 0);
    add(0, 0, 1, 0, JUNK,   ID,  WPC, 0, 0);
    add(0, 1, 1, 0, OP_BAD, IFH, IRL, 0, 0);
    add(0, 0, 1, 0, JUNK,   ID,  ILL | WPC, 0, 0);
    add(0, 0, 1, 0, JUNK,   IFH, NONE, 0, 0);
    // halt, then resume: only the HALT_RESUME=1 instance leaves HALTED.
    add(0, 1, 1, 0, OP_HALT, IFH, IRL, 0, 0);
    add(0, 0, 1, 0, JUNK,   ID,  NONE, 0, 0);
    add(0, 0, 1, 0, JUNK,   HTD, HLT, 0, 0);
    add(0, 1, 1, 0, OP_R,   HTD, HLT, 0, 0);
    add(0, 0, 1, 1, JUNK,   HTD, HLT | WPC, 0, 0);
    set_nr(HTD, HLT);
    add(0, 0, 1, 0, JUNK,   IFH, NONE, 0, 0);
    set_nr(HTD, HLT);
    add(1, 0, 1, 0, JUNK,   IFH, NONE, 0, 0);
    add(0, 0, 1, 0, JUNK,   IFH, NONE, 0, 0);
    // Reset during a MEM stall: immediate IFH, no write_pc.
    add(0, 1, 0, 0, OP_LW,  IFH, IRL, 0, 0);
    add(0, 0, 0, 0, JUNK,   ID,  RR, 0, 0);
    add(0, 0, 0, 0, JUNK,   EX,  IMM | CF | CAD, 6'b100000, 0);
    add(0, 0, 0, 0, JUNK,   MEM, CAD | RD, 0, 0);
    add(1, 1, 1, 0, JUNK,   IFH, NONE, 0, 0);
    add(0, 0, 1, 0, JUNK,   IFH, NONE, 0, 0);

    // Apply table: drive on falling edge, compare 1 time unit later.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].r, vecs[i].v, vecs[i].m, vecs[i].s, vecs[i].opc);
      #1;
      check("stage",      i, 32'(stage),      32'(vecs[i].stg));
      check("strobes",    i, 32'(act_str),    32'(vecs[i].str));
      check("fnction",    i, 32'(fnction),    32'(vecs[i].fn));
      check("branch",     i, 32'(branch),     32'(vecs[i].br));
      check("nr_stage",   i, 32'(n_stage),    32'(vecs[i].stg_nr));
      check("nr_strobes", i, 32'(act_str_nr), 32'(vecs[i].str_nr));
      check("nr_fnction", i, 32'(n_fnction),  32'(vecs[i].fn));
      check("nr_branch",  i, 32'(n_branch),   32'(vecs[i].br));
    end

    // Long stall: lw with ten stalled MEM cycles. Steps: 0 IFH, 1 ID, 2 EX,
    // 3..13 MEM (ready on 13), 14 WB. mem_ready high before MEM is ignored.
    rd_cnt = 0; wr_cnt = 0; wpc_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      drive(1'b0, c == 0, (c < 3) || (c >= 13), 1'b0, (c == 0) ? OP_LW : OP_SW);
      #1;
      rd_cnt  += int'(read_data);
      wr_cnt  += int'(write_reg);
      wpc_cnt += int'(write_pc);
      if (c == 12) check("stall_mem", c, 32'(stage), 32'(MEM));
      if (c == 14) check("stall_wb",  c, 32'(stage), 32'(WB));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 1'b0, OP_R);
    #1;
    check("stall_end",   15, 32'(stage), 32'(IFH));
    check("stall_rd",    15, 32'(rd_cnt), 32'd12);
    check("stall_wr",    15, 32'(wr_cnt), 32'd1);
    check("stall_wpc",   15, 32'(wpc_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
